hazard_stall_unit: RTL and testbench

- Stall/flush controller. It is the complement of the bypass (forwarding) path: it handles every hazard that bypassing cannot resolve.
- It watches the ID-stage source registers against the EX/MEM destinations.
- It freezes PC and IF/ID, inserts bubbles into ID/EX, and flushes IF/ID on a taken branch or a jump.
- A small FSM commits to multi-cycle stalls: load followed by a dependent branch needs 2 bubbles.

---
 rtl/hazard_stall_unit_if.sv | 47 ++++
 rtl/hazard_stall_unit.sv | 97 +++++++++
 tb/tb_hazard_stall_unit.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_if.sv
// Hazard stall unit bus: ID/EX/MEM hazard inputs and pipeline control outputs.
// HAZARD_PERF_CNT_EN adds the stall/flush performance counter outputs.
interface hazard_stall_unit_if #(
   parameter int unsigned REG_W = 5
`ifdef HAZARD_PERF_CNT_EN
   , parameter int unsigned CNT_W = 32
`endif
);
   logic [REG_W-1:0] registerRsID;
   logic [REG_W-1:0] registerRtID;
   logic             useRtID;
   logic             branchID;
   logic             branchTakenID;
   logic             jumpID;
   logic             memReadEX;
   logic             regWriteEX;
   logic [REG_W-1:0] registerRdEX;
   logic             memReadMEM;
   logic [REG_W-1:0] registerRdMEM;
   logic             pcWrite;
   logic             ifidWrite;
   logic             idexBubble;
   logic             ifidFlush;
   logic             stallActive;
`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stallCount;
   logic [CNT_W-1:0] flushCount;
`endif

   modport slave (
      input  registerRsID, registerRtID, useRtID, branchID, branchTakenID, jumpID,
      input  memReadEX, regWriteEX, registerRdEX, memReadMEM, registerRdMEM,
`ifdef HAZARD_PERF_CNT_EN
      output stallCount, flushCount,
`endif
      output pcWrite, ifidWrite, idexBubble, ifidFlush, stallActive
   );

   modport master (
      output registerRsID, registerRtID, useRtID, branchID, branchTakenID, jumpID,
      output memReadEX, regWriteEX, registerRdEX, memReadMEM, registerRdMEM,
`ifdef HAZARD_PERF_CNT_EN
      input  stallCount, flushCount,
`endif
      input  pcWrite, ifidWrite, idexBubble, ifidFlush, stallActive
   );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for hazards that forwarding cannot resolve (Mealy outputs).
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_stall_unit #(
   parameter int unsigned REG_W = 5
`ifdef HAZARD_PERF_CNT_EN
   , parameter int unsigned CNT_W = 32
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   hazard_stall_unit_if.slave bus
);
   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   logic [0:0]       r_state;
   logic [0:0]       w_state_nxt;
   logic [REG_W-1:0] w_rd_ex;
   logic [REG_W-1:0] w_rd_mem;
   logic             w_m_ex;
   logic             w_m_mem;
   logic             w_need2;
   logic             w_need1;

   assign w_rd_ex  = bus.registerRdEX;
   assign w_rd_mem = bus.registerRdMEM;

   // Register 0 is hardwired and never creates a dependency.
   assign w_m_ex  = (w_rd_ex != '0) && ((w_rd_ex == bus.registerRsID) ||
                    (bus.useRtID && (w_rd_ex == bus.registerRtID)));
   assign w_m_mem = (w_rd_mem != '0) && ((w_rd_mem == bus.registerRsID) ||
                    (bus.useRtID && (w_rd_mem == bus.registerRtID)));

   assign w_need2 = bus.branchID && bus.memReadEX && w_m_ex;
   assign w_need1 = (bus.memReadEX && w_m_ex) ||
                    (bus.branchID && bus.regWriteEX && w_m_ex) ||
                    (bus.branchID && bus.memReadMEM && w_m_mem);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_RUN;
      else        r_state <= w_state_nxt;
   end

   // Next state and outputs; a stall always suppresses the flush.
   always_comb begin
      w_state_nxt     = ST_RUN;
      bus.pcWrite     = 1'b1;
      bus.ifidWrite   = 1'b1;
      bus.idexBubble  = 1'b0;
      bus.ifidFlush   = 1'b0;
      bus.stallActive = 1'b0;
      if (!rst_n) begin
         bus.pcWrite    = 1'b0;
         bus.ifidWrite  = 1'b0;
         bus.idexBubble = 1'b1;
      end else begin
         case (r_state)
            ST_HOLD: begin
               bus.pcWrite     = 1'b0;
               bus.ifidWrite   = 1'b0;
               bus.idexBubble  = 1'b1;
               bus.stallActive = 1'b1;
            end
            default: begin
               if (w_need2 || w_need1) begin
                  bus.pcWrite     = 1'b0;
                  bus.ifidWrite   = 1'b0;
                  bus.idexBubble  = 1'b1;
                  bus.stallActive = 1'b1;
                  if (w_need2) w_state_nxt = ST_HOLD;
               end else begin
                  bus.ifidFlush = bus.jumpID || (bus.branchID && bus.branchTakenID);
               end
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   // Saturating event counters, visible one cycle after the event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (bus.stallActive && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (bus.ifidFlush && (r_flush_cnt != '1))   r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign bus.stallCount = r_stall_cnt;
   assign bus.flushCount = r_flush_cnt;
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios plus a random run
// against a bubble-budget reference model.
module tb_hazard_stall_unit;
   localparam int unsigned REG_W = 5;
`ifdef HAZARD_PERF_CNT_EN
   localparam int unsigned CNT_W = 4;
`endif
   // Output vector order: {pcWrite, ifidWrite, idexBubble, ifidFlush, stallActive}
   localparam logic [4:0] V_RUN = 5'b11000;
   localparam logic [4:0] V_STL = 5'b00101;
   localparam logic [4:0] V_FLS = 5'b11010;
   localparam logic [4:0] V_RST = 5'b00100;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   m_left;

`ifdef HAZARD_PERF_CNT_EN
   hazard_stall_unit_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();
   hazard_stall_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
   hazard_stall_unit_if #(.REG_W(REG_W)) bus ();
   hazard_stall_unit #(.REG_W(REG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [4:0] obs();
      return {bus.pcWrite, bus.ifidWrite, bus.idexBubble, bus.ifidFlush, bus.stallActive};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.registerRsID  = '0;
      bus.registerRtID  = '0;
      bus.useRtID       = 1'b0;
      bus.branchID      = 1'b0;
      bus.branchTakenID = 1'b0;
      bus.jumpID        = 1'b0;
      bus.memReadEX     = 1'b0;
      bus.regWriteEX    = 1'b0;
      bus.registerRdEX  = '0;
      bus.memReadMEM    = 1'b0;
      bus.registerRdMEM = '0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #2;
   endtask

   // Reference: a source depends on a nonzero destination; loads feeding a branch cost two bubbles.
   function automatic int need_now();
      bit dep_ex, dep_mem;
      int n;
      dep_ex  = (bus.registerRdEX != 0) && ((bus.registerRdEX == bus.registerRsID) ||
                (bus.useRtID && (bus.registerRdEX == bus.registerRtID)));
      dep_mem = (bus.registerRdMEM != 0) && ((bus.registerRdMEM == bus.registerRsID) ||
                (bus.useRtID && (bus.registerRdMEM == bus.registerRtID)));
      n = 0;
      if (bus.memReadEX && dep_ex) n = 1;
      if (bus.branchID && bus.regWriteEX && dep_ex) n = 1;
      if (bus.branchID && bus.memReadMEM && dep_mem) n = 1;
      if (bus.branchID && bus.memReadEX && dep_ex) n = 2;
      return n;
   endfunction

   task automatic test_reset();
      idle();
      bus.memReadEX    = 1'b1;
      bus.registerRdEX = 5'd8;
      bus.registerRsID = 5'd8;
      bus.jumpID       = 1'b1;
      rst_n = 1'b0;
      #2;
      total++;
      if (obs() !== V_RST) begin bad++; $display("FAIL reset_vals got=%b want=%b", obs(), V_RST); end
      tick();
      total++;
      if (obs() !== V_RST) begin bad++; $display("FAIL reset_hold got=%b want=%b", obs(), V_RST); end
      idle();
      rst_n = 1'b1;
      #2;
      total++;
      if (obs() !== V_RUN) begin bad++; $display("FAIL reset_first_run got=%b want=%b", obs(), V_RUN); end
      tick();
   endtask

   task automatic test_load_use();
      idle();
      bus.memReadEX    = 1'b1;
      bus.registerRdEX = 5'd8;
      bus.registerRsID = 5'd8;
      #2;
      total++;
      if (obs() !== V_STL) begin bad++; $display("FAIL load_use_stall got=%b want=%b", obs(), V_STL); end
      tick();
      bus.memReadEX     = 1'b0;
      bus.registerRdEX  = '0;
      bus.memReadMEM    = 1'b1;
      bus.registerRdMEM = 5'd8;
      #2;
      total++;
      if (obs() !== V_RUN) begin bad++; $display("FAIL load_use_release got=%b want=%b", obs(), V_RUN); end
      tick();
   endtask

   task automatic test_load_branch();
      logic [4:0] exp_seq [4];
      exp_seq[0] = V_STL; exp_seq[1] = V_STL; exp_seq[2] = V_STL; exp_seq[3] = V_FLS;
      idle();
      bus.memReadEX    = 1'b1;
      bus.registerRdEX = 5'd9;
      bus.branchID     = 1'b1;
      bus.registerRtID = 5'd9;
      bus.useRtID      = 1'b1;
      bus.registerRsID = 5'd4;
      for (int c = 0; c < 4; c++) begin
         if (c == 1) begin
            bus.memReadEX     = 1'b0;
            bus.registerRdEX  = '0;
            bus.memReadMEM    = 1'b1;
            bus.registerRdMEM = 5'd9;
         end
         if (c == 3) begin
            bus.memReadMEM    = 1'b0;
            bus.registerRdMEM = '0;
            bus.branchTakenID = 1'b1;
         end
         #2;
         total++;
         if (obs() !== exp_seq[c])
            begin bad++; $display("FAIL load_branch_c%0d got=%b want=%b", c, obs(), exp_seq[c]); end
         tick();
      end
   endtask

   task automatic test_alu_branch();
      idle();
      bus.regWriteEX    = 1'b1;
      bus.registerRdEX  = 5'd3;
      bus.branchID      = 1'b1;
      bus.branchTakenID = 1'b1;
      bus.registerRsID  = 5'd3;
      #2;
      total++;
      if (obs() !== V_STL) begin bad++; $display("FAIL alu_branch_stall got=%b want=%b", obs(), V_STL); end
      tick();
      bus.regWriteEX   = 1'b0;
      bus.registerRdEX = '0;
      #2;
      total++;
      if (obs() !== V_FLS) begin bad++; $display("FAIL alu_branch_flush got=%b want=%b", obs(), V_FLS); end
      tick();
   endtask

   task automatic test_reg_zero();
      idle();
      bus.memReadEX    = 1'b1;
      bus.registerRdEX = '0;
      bus.registerRsID = '0;
      #2;
      total++;
      if (obs() !== V_RUN) begin bad++; $display("FAIL reg0_no_stall got=%b want=%b", obs(), V_RUN); end
      tick();
      idle();
      bus.jumpID = 1'b1;
      #2;
      total++;
      if (obs() !== V_FLS) begin bad++; $display("FAIL jump_flush got=%b want=%b", obs(), V_FLS); end
      tick();
      bus.jumpID        = 1'b0;
      bus.branchTakenID = 1'bx;
      #2;
      total++;
      if (obs() !== V_RUN) begin bad++; $display("FAIL jump_one_cycle got=%b want=%b", obs(), V_RUN); end
      bus.branchTakenID = 1'b0;
      bus.memReadEX     = 1'b1;
      bus.registerRdEX  = 5'd5;
      bus.registerRtID  = 5'd5;
      bus.registerRsID  = 5'd6;
      #2;
      total++;
      if (obs() !== V_RUN) begin bad++; $display("FAIL rt_unused got=%b want=%b", obs(), V_RUN); end
      tick();
      idle();
   endtask

   task automatic test_reset_in_hold();
      idle();
      bus.memReadEX    = 1'b1;
      bus.registerRdEX = 5'd7;
      bus.branchID     = 1'b1;
      bus.registerRsID = 5'd7;
      #2;
      total++;
      if (obs() !== V_STL) begin bad++; $display("FAIL hold_entry got=%b want=%b", obs(), V_STL); end
      tick();
      idle();
      bus.jumpID = 1'b1;
      #2;
      total++;
      if (obs() !== V_STL) begin bad++; $display("FAIL hold_ignores_inputs got=%b want=%b", obs(), V_STL); end
      rst_n = 1'b0;
      #1;
      total++;
      if (obs() !== V_RST) begin bad++; $display("FAIL hold_async_reset got=%b want=%b", obs(), V_RST); end
      tick();
      idle();
      rst_n = 1'b1;
      #2;
      total++;
      if (obs() !== V_RUN) begin bad++; $display("FAIL hold_release got=%b want=%b", obs(), V_RUN); end
      tick();
      #2;
      total++;
      if (obs() !== V_RUN) begin bad++; $display("FAIL hold_no_residual got=%b want=%b", obs(), V_RUN); end
   endtask

   task automatic test_random();
      logic [4:0] exp_v;
      int n;
      do_reset();
      m_left = 0;
      for (int i = 0; i < 600; i++) begin
         rst_n             = ($urandom_range(0, 39) != 0);
         bus.registerRsID  = REG_W'($urandom_range(0, 3));
         bus.registerRtID  = REG_W'($urandom_range(0, 3));
         bus.registerRdEX  = REG_W'($urandom_range(0, 3));
         bus.registerRdMEM = REG_W'($urandom_range(0, 3));
         bus.useRtID       = 1'($urandom_range(0, 1));
         bus.branchID      = 1'($urandom_range(0, 1));
         bus.branchTakenID = 1'($urandom_range(0, 1));
         bus.jumpID        = ($urandom_range(0, 3) == 0);
         bus.memReadEX     = 1'($urandom_range(0, 1));
         bus.regWriteEX    = 1'($urandom_range(0, 1));
         bus.memReadMEM    = 1'($urandom_range(0, 1));
         #2;
         n = need_now();
         if (!rst_n) begin
            exp_v  = V_RST;
            m_left = 0;
         end else if (m_left > 0) begin
            exp_v = V_STL;
         end else if (n > 0) begin
            exp_v = V_STL;
         end else begin
            exp_v = {2'b11, 1'b0, bus.jumpID | (bus.branchID & bus.branchTakenID), 1'b0};
         end
         total++;
         if (obs() !== exp_v) begin bad++; $display("FAIL random_%0d got=%b want=%b", i, obs(), exp_v); end
         tick();
         if (rst_n) begin
            if (m_left > 0)  m_left = m_left - 1;
            else if (n == 2) m_left = 1;
         end
      end
      rst_n = 1'b1;
      idle();
      tick();
   endtask

`ifdef HAZARD_PERF_CNT_EN
   task automatic test_perf_cnt();
      logic [CNT_W-1:0] all1;
      all1 = '1;
      do_reset();
      total++;
      if (bus.stallCount !== CNT_W'(0)) begin bad++; $display("FAIL cnt_reset got=%0d want=0", bus.stallCount); end
      test_load_use();
      test_reg_zero();
      #2;
      total++;
      if (bus.stallCount !== CNT_W'(1)) begin bad++; $display("FAIL stall_count got=%0d want=1", bus.stallCount); end
      total++;
      if (bus.flushCount !== CNT_W'(1)) begin bad++; $display("FAIL flush_count got=%0d want=1", bus.flushCount); end
      idle();
      bus.memReadEX    = 1'b1;
      bus.registerRdEX = 5'd2;
      bus.registerRsID = 5'd2;
      for (int i = 0; i < 20; i++) tick();
      total++;
      if (bus.stallCount !== all1) begin bad++; $display("FAIL stall_saturate got=%0d want=%0d", bus.stallCount, all1); end
      idle();
      tick();
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      idle();
      tick();
      test_reset();
      test_load_use();
      test_load_branch();
      test_alu_branch();
      test_reg_zero();
      test_reset_in_hold();
      test_random();
`ifdef HAZARD_PERF_CNT_EN
      test_perf_cnt();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
